// File: rtl/keypad_pkg.sv
// Shared types, key map and encode helpers for the 4x4 hex keypad scanner.
// Key map index is {row, column}.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Entry 0 is row0/col0; rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      4'b1110: col_index = 2'd0;
      4'b1101: col_index = 2'd1;
      4'b1011: col_index = 2'd2;
      4'b0111: col_index = 2'd3;
      default: col_index = 2'd0;
    endcase
  endfunction

  // Lowest low row wins when several rows are pulled down together.
  function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [3:0] col);
    logic [1:0] row_idx;
    if (!rows[0]) begin
      row_idx = 2'd0;
    end else if (!rows[1]) begin
      row_idx = 2'd1;
    end else if (!rows[2]) begin
      row_idx = 2'd2;
    end else begin
      row_idx = 2'd3;
    end
    key_code = KEY_MAP[{row_idx, col_index(col)}];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so
// idle active-low lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability-resolving flop pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes one column per slot, debounces presses and
// releases, and emits one tecla_valida pulse per accepted key.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_TICKS     = 27000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  localparam int PW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    r_col;
  logic [3:0]    w_col_nxt;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nxt;
  logic [3:0]    r_tecla;
  logic [3:0]    w_tecla_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_pressed;
  logic          w_pressed_nxt;
  logic [3:0]    w_fil;
  logic          w_tick;
  logic [3:0]    w_col_rot;

  sync_2ff #(.W(4)) u_fil_sync (
    .clk (clk),
    .rst (rst),
    .i_d (fil),
    .o_q (w_fil)
  );

  assign w_tick    = (r_presc == PW'(SCAN_TICKS - 1));
  assign w_col_rot = {r_col[2:0], r_col[3]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions, all taken on the end-of-slot tick.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_tecla_nxt = r_tecla;
    w_valid_nxt = 1'b0;
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_fil != 4'hF) begin
            w_cand_nxt = w_fil;
            if (DEBOUNCE_SCANS == 1) begin
              w_tecla_nxt = key_code(w_fil, r_col);
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_cnt_nxt   = CW'(1);
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            w_col_nxt = w_col_rot;
          end
        end
        DEBOUNCE: begin
          if (w_fil == r_cand) begin
            if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
              w_tecla_nxt = key_code(r_cand, r_col);
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_cnt_nxt   = '0;
            w_col_nxt   = w_col_rot;
            w_state_nxt = SCAN;
          end
        end
        HOLD: begin
          // Only a fully released matrix counts toward release; extra keys reset it.
          if (w_fil == 4'hF) begin
            if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
              w_cnt_nxt   = '0;
              w_col_nxt   = w_col_rot;
              w_state_nxt = SCAN;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_col_nxt   = COL_RESET;
          w_state_nxt = SCAN;
        end
      endcase
    end else begin
      w_valid_nxt = 1'b0;
    end
    w_pressed_nxt = (w_state_nxt == HOLD) ||
                    ((w_state_nxt == DEBOUNCE) && (w_cnt_nxt > CW'(1)));
  end

  // Prescaler, scan datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc   <= '0;
      r_cnt     <= '0;
      r_col     <= COL_RESET;
      r_cand    <= 4'hF;
      r_tecla   <= 4'h0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_cnt     <= w_cnt_nxt;
      r_col     <= w_col_nxt;
      r_cand    <= w_cand_nxt;
      r_tecla   <= w_tecla_nxt;
      r_valid   <= w_valid_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  assign col              = r_col;
  assign tecla            = r_tecla;
  assign tecla_valida     = r_valid;
  assign tecla_presionada = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_TICKS=4, DEBOUNCE_SCANS=3) with a
// behavioural key matrix pulling rows low under active columns.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  fil;
  logic [3:0]  col;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic        tecla_presionada;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  int         pulse_cnt  = 0;
  logic [3:0] last_code  = 4'h0;
  logic       prev_v     = 1'b0;
  logic [3:0] prev_tecla = 4'h0;
  int         consec     = 0;
  int         glitch     = 0;

  logic [3:0] exp_codes [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .fil              (fil),
    .col              (col),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .tecla_presionada (tecla_presionada)
  );

  always #5 clk = ~clk;

  always_comb begin
    fil = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) fil[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tecla_valida) begin
        pulse_cnt <= pulse_cnt + 1;
        last_code <= tecla;
      end
      if (tecla_valida && prev_v) consec <= consec + 1;
      if ((tecla !== prev_tecla) && !tecla_valida) glitch <= glitch + 1;
    end
    prev_v     <= tecla_valida;
    prev_tecla <= tecla;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pulse(input int max, output bit ok);
    int p0;
    p0 = pulse_cnt;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (pulse_cnt != p0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col_change(input logic [3:0] from, input int max, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (col != from) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic wait_col_rise(input logic [3:0] target, input int max, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      prev = col;
      step();
      if (col == target && prev != target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    keys = 16'h0000;
    repeat (3) step();
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", col); end
    total++; if (tecla !== 4'h0) begin bad++; $display("FAIL reset_tecla got=%h want=0", tecla); end
    total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL reset_valida got=%b want=0", tecla_valida); end
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL reset_presionada got=%b want=0", tecla_presionada); end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    logic [3:0] exp_col;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_col = 4'b1111;
      exp_col[(e/4)%4] = 1'b0;
      total++; if (col !== exp_col) begin bad++; $display("FAIL idle_col e=%0d got=%b want=%b", e, col, exp_col); end
      total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL idle_valida e=%0d got=%b want=0", e, tecla_valida); end
    end
    total++; if (tecla !== 4'h0) begin bad++; $display("FAIL idle_tecla got=%h want=0", tecla); end
  endtask

  task automatic test_press_6();
    int p0;
    int n;
    bit ok;
    p0   = pulse_cnt;
    keys = 16'h0001 << 6;
    repeat (60) step();
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL press6_pulses got=%0d want=1", pulse_cnt - p0); end
    total++; if (last_code !== 4'h6) begin bad++; $display("FAIL press6_code got=%h want=6", last_code); end
    total++; if (tecla !== 4'h6) begin bad++; $display("FAIL press6_tecla got=%h want=6", tecla); end
    total++; if (col !== 4'b1011) begin bad++; $display("FAIL press6_frozen got=%b want=1011", col); end
    total++; if (tecla_presionada !== 1'b1) begin bad++; $display("FAIL press6_presionada got=%b want=1", tecla_presionada); end
    keys = 16'h0000;
    wait_col_change(4'b1011, 30, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL press6_resume got=timeout want=col change"); end
    total++; if (col !== 4'b0111) begin bad++; $display("FAIL press6_next_col got=%b want=0111", col); end
    total++; if (n < 11 || n > 14) begin bad++; $display("FAIL press6_release_delay got=%0d want=11..14", n); end
  endtask

  task automatic test_bounce();
    int p0;
    int n;
    bit ok;
    wait_col_rise(4'b1110, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bounce_sync got=timeout want=col 1110"); end
    p0   = pulse_cnt;
    keys = 16'h0001;
    repeat (4) step();
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL bounce_detect_col got=%b want=1110", col); end
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL bounce_cnt1_presionada got=%b want=0", tecla_presionada); end
    keys = 16'h0000;
    repeat (4) step();
    total++; if (col !== 4'b1101) begin bad++; $display("FAIL bounce_abort_col got=%b want=1101", col); end
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL bounce_no_pulse got=%0d want=0", pulse_cnt - p0); end
    keys = 16'h0001;
    wait_pulse(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL bounce_accept got=timeout want=pulse"); end
    total++; if (last_code !== 4'h1) begin bad++; $display("FAIL bounce_code got=%h want=1", last_code); end
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", pulse_cnt - p0); end
    keys = 16'h0000;
    wait_col_change(4'b1110, 40, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL bounce_resume got=timeout want=col change"); end
  endtask

  task automatic test_full_map();
    int p0;
    int n;
    bit ok;
    logic [3:0] frozen;
    p0 = pulse_cnt;
    for (int k = 0; k < 16; k++) begin
      keys = 16'h0001 << k;
      wait_pulse(80, ok);
      total++; if (!ok) begin bad++; $display("FAIL map_pulse k=%0d got=timeout want=pulse", k); end
      total++; if (last_code !== exp_codes[k]) begin bad++; $display("FAIL map_code k=%0d got=%h want=%h", k, last_code, exp_codes[k]); end
      frozen = col;
      keys   = 16'h0000;
      wait_col_change(frozen, 40, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL map_release k=%0d got=timeout want=col change", k); end
    end
    total++; if (pulse_cnt - p0 != 16) begin bad++; $display("FAIL map_pulses got=%0d want=16", pulse_cnt - p0); end
  endtask

  task automatic test_held_second();
    int p0;
    int n;
    bit ok;
    p0   = pulse_cnt;
    keys = 16'h0001 << 13;
    wait_pulse(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL held_first got=timeout want=pulse"); end
    total++; if (last_code !== 4'h0) begin bad++; $display("FAIL held_first_code got=%h want=0", last_code); end
    keys = keys | (16'h0001 << 5);
    repeat (40) step();
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL held_second_ignored got=%0d want=1", pulse_cnt - p0); end
    total++; if (tecla !== 4'h0) begin bad++; $display("FAIL held_tecla got=%h want=0", tecla); end
    keys = 16'h0001 << 5;
    repeat (40) step();
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL held_partial_release got=%0d want=1", pulse_cnt - p0); end
    total++; if (col !== 4'b1101) begin bad++; $display("FAIL held_col got=%b want=1101", col); end
    keys = 16'h0000;
    wait_col_change(4'b1101, 40, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL held_release got=timeout want=col change"); end
    keys = 16'h0001 << 5;
    wait_pulse(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL held_repress got=timeout want=pulse"); end
    total++; if (last_code !== 4'h5) begin bad++; $display("FAIL held_repress_code got=%h want=5", last_code); end
    keys = 16'h0000;
    wait_col_change(4'b1101, 40, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL held_final_release got=timeout want=col change"); end
  endtask

  task automatic test_reset_mid_debounce();
    int p0;
    bit ok;
    wait_col_rise(4'b1110, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstdb_sync got=timeout want=col 1110"); end
    p0   = pulse_cnt;
    keys = 16'h0001;
    repeat (8) step();
    total++; if (tecla_presionada !== 1'b1) begin bad++; $display("FAIL rstdb_cnt2_presionada got=%b want=1", tecla_presionada); end
    total++; if (tecla !== 4'h5) begin bad++; $display("FAIL rstdb_pre_tecla got=%h want=5", tecla); end
    rst  = 1'b0;
    keys = 16'h0000;
    #1;
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL rstdb_col got=%b want=1110", col); end
    total++; if (tecla !== 4'h0) begin bad++; $display("FAIL rstdb_tecla got=%h want=0", tecla); end
    total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL rstdb_valida got=%b want=0", tecla_valida); end
    total++; if (tecla_presionada !== 1'b0) begin bad++; $display("FAIL rstdb_presionada got=%b want=0", tecla_presionada); end
    step();
    rst = 1'b1;
    repeat (40) step();
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL rstdb_no_pulse got=%0d want=0", pulse_cnt - p0); end
    total++; if (tecla !== 4'h0) begin bad++; $display("FAIL rstdb_tecla_after got=%h want=0", tecla); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_6();
    test_bounce();
    test_full_map();
    test_held_second();
    test_reset_mid_debounce();
    total++; if (consec != 0) begin bad++; $display("FAIL valida_back_to_back got=%0d want=0", consec); end
    total++; if (glitch != 0) begin bad++; $display("FAIL tecla_without_valida got=%0d want=0", glitch); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix hex keypad and drives the operand-capture logic. It steps one active-low column strobe at a time and samples the row lines. Each key is debounced, then encoded to a 4-bit hex code on tecla. Each debounced press produces exactly one single-cycle tecla_valida pulse.

Parameters:
SCAN_TICKS, 27000, clk cycles per column slot (~1 ms at 27 MHz); minimum 2.
DEBOUNCE_SCANS, 10, consecutive matching samples needed to accept a press and to accept a release; minimum 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
fil  input  4  keypad rows; asynchronous; active-low with external pull-ups
col  output 4  column strobes; active-low one-hot
tecla  output 4  hex code of the last accepted key; held until the next accepted key
tecla_valida  output 1  one-clk pulse per accepted press
tecla_presionada  output 1  high in DEBOUNCE (count ≥ 2) and HOLD

Behaviour:
- Reset (rst=0, async): col=4'b1110; tecla=0; tecla_valida=0; tecla_presionada=0; state=SCAN; prescaler=0; debounce count=0; synchronizer flops=4'b1111.
- Input path: fil passes through a 2-FF synchronizer, giving fil_s (2 clk latency). All decisions use fil_s only.
- Prescaler: counts 0..SCAN_TICKS-1 and wraps. tick=1 when prescaler==SCAN_TICKS-1. Rows are sampled only on tick, at the end of the slot, so the column has settled.
- Key map, as row r / active column c → tecla:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Multiple rows low in one sample: lowest row index wins for encoding. The full 4-bit row pattern is stored for matching.
- SCAN state:
  - On tick with fil_s==4'hF: rotate col left (1110→1101→1011→0111→1110).
  - On tick with any row low: store candidate {col index, row pattern}; count=1; col frozen; go to DEBOUNCE.
- DEBOUNCE state:
  - On tick with pattern equal to the candidate: count++.
  - When count reaches DEBOUNCE_SCANS: load tecla from the map, pulse tecla_valida in the next clk cycle, go to HOLD.
  - On tick with a different pattern (release or bounce): count=0, rotate col, go to SCAN. No pulse.
  - DEBOUNCE_SCANS=1: a detection tick accepts the key immediately (SCAN→HOLD, pulse next cycle).
- HOLD state:
  - col stays frozen. On tick: fil_s==4'hF increments the release count; anything else clears it.
  - Release count reaching DEBOUNCE_SCANS: rotate col, go to SCAN.
  - A second key pressed while held is ignored. No auto-repeat.
- tecla_valida is never high for two consecutive cycles.
- Acceptance latency: first low sample at tick k gives the pulse 1 clk after tick k+DEBOUNCE_SCANS-1, i.e. (DEBOUNCE_SCANS-1)*SCAN_TICKS+1 clk.
- tecla changes only in the same cycle that tecla_valida rises, so consumers sample both together.
- Reset mid-debounce or mid-hold: returns to reset values immediately. The pending press is dropped and no pulse is emitted after reset release.

Decomposition:
- Package keypad_pkg holds:
  - state_t enum {SCAN, DEBOUNCE, HOLD}
  - the 16-entry key-map constant (row,col → 4-bit code)
  - COL_RESET = 4'b1110
- One sub-module: sync_2ff, a parameterized-width 2-flop synchronizer with async active-low reset to all-ones. It is instantiated for fil.

Test Plan (SCAN_TICKS=4, DEBOUNCE_SCANS=3; model the keypad by pulling fil[r] low while col[c]==0):
- Reset and idle: no key, 40 clk → col cycles 1110,1101,1011,0111,1110 every 4 clk; tecla=0; tecla_valida never high.
- Clean press of row1/col2 ("6") held 60 clk → exactly one tecla_valida pulse; tecla=4'h6; col frozen at 1011 until release; scanning resumes 3 ticks after release.
- Bounce: row0/col0 low for 1 tick then high, then stable → first attempt aborts with no pulse; after stable press, one pulse with tecla=4'h1.
- Full map: press each of the 16 keys sequentially with release between → 16 pulses, codes in order 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D.
- Held key + second key: hold "0" (r3/c1) and press "5" during HOLD → one pulse only, tecla=0; "5" is accepted only after both are released and "5" is pressed again.
- Reset mid-DEBOUNCE: assert rst after 2 matching ticks → outputs return to reset values; after rst=1 with the key still released, no pulse.
